// File: rtl/wb_arbiter_2m_rr.sv
// wb_arbiter_2m_rr: two-master round-robin Wishbone arbiter with a bus-timeout watchdog
module wb_arbiter_2m_rr #(
  parameter int AWIDTH  = 16,
  parameter int TIMEOUT = 255,
  parameter int TWIDTH  = 8
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              M0_cyc_i,
  input  logic              M0_stb_i,
  input  logic              M0_we_i,
  input  logic [3:0]        M0_sel_i,
  input  logic [AWIDTH-1:0] M0_adr_i,
  input  logic [31:0]       M0_dat_i,
  output logic [31:0]       M0_dat_o,
  output logic              M0_ack_o,
  output logic              M0_err_o,
  input  logic              M1_cyc_i,
  input  logic              M1_stb_i,
  input  logic              M1_we_i,
  input  logic [3:0]        M1_sel_i,
  input  logic [AWIDTH-1:0] M1_adr_i,
  input  logic [31:0]       M1_dat_i,
  output logic [31:0]       M1_dat_o,
  output logic              M1_ack_o,
  output logic              M1_err_o,
  output logic              S_cyc_o,
  output logic              S_stb_o,
  output logic              S_we_o,
  output logic [3:0]        S_sel_o,
  output logic [AWIDTH-1:0] S_adr_o,
  output logic [31:0]       S_dat_o,
  input  logic [31:0]       S_dat_i,
  input  logic              S_ack_i,
  output logic [1:0]        gnt_o,
  output logic              timeout_o
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nxt;
  logic last_gnt;
  logic [TWIDTH-1:0] cnt;
  logic g0, g1, act, req_stb, expire;
  always_comb begin
    g0 = state == GNT0;
    g1 = state == GNT1;
    // dropping CYC releases the slave in the same cycle, before the FSM reacts
    act = (g0 & M0_cyc_i) | (g1 & M1_cyc_i);
    req_stb = act & (g0 ? M0_stb_i : M1_stb_i);
    expire = req_stb & ~S_ack_i & (cnt == TWIDTH'(TIMEOUT - 1));
    S_cyc_o = act & ~expire;
    S_stb_o = req_stb & ~expire;
    S_we_o = act & (g0 ? M0_we_i : M1_we_i);
    S_sel_o = act ? (g0 ? M0_sel_i : M1_sel_i) : '0;
    S_adr_o = act ? (g0 ? M0_adr_i : M1_adr_i) : '0;
    S_dat_o = act ? (g0 ? M0_dat_i : M1_dat_i) : '0;
    M0_dat_o = S_dat_i;
    M1_dat_o = S_dat_i;
    M0_ack_o = S_ack_i & M0_stb_i & g0;
    M1_ack_o = S_ack_i & M1_stb_i & g1;
    M0_err_o = expire & g0;
    M1_err_o = expire & g1;
    gnt_o = {g1, g0};
    timeout_o = expire;
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (M0_cyc_i & (~M1_cyc_i | last_gnt)) ? GNT0 : M1_cyc_i ? GNT1 : IDLE;
    else if (~act | expire)
      state_nxt = IDLE;
  end
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= IDLE;
      last_gnt <= 1'b1;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE) last_gnt <= state_nxt == GNT1;
      cnt <= (req_stb & ~S_ack_i & ~expire) ? cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_2m_rr.sv
// tb_wb_arbiter_2m_rr: directed and randomized checks of the two-master round-robin arbiter
module tb_wb_arbiter_2m_rr;
  localparam int AW = 16;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] cyc, stb, we, ack_o, err_o, gnt;
  logic [3:0] sel [2];
  logic [AW-1:0] adr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic s_cyc, s_stb, s_we, s_ack, timeout;
  logic [3:0] s_sel;
  logic [AW-1:0] s_adr;
  logic [31:0] s_wdat, s_rdat;
  int checks = 0;
  int fails = 0;
  int own = -1;
  int lst = 1;
  int waited = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m_rr #(.AWIDTH(AW), .TIMEOUT(TO), .TWIDTH(8)) dut (
    .wb_clk(clk), .wb_rst(rst),
    .M0_cyc_i(cyc[0]), .M0_stb_i(stb[0]), .M0_we_i(we[0]), .M0_sel_i(sel[0]),
    .M0_adr_i(adr[0]), .M0_dat_i(wdat[0]), .M0_dat_o(rdat[0]), .M0_ack_o(ack_o[0]), .M0_err_o(err_o[0]),
    .M1_cyc_i(cyc[1]), .M1_stb_i(stb[1]), .M1_we_i(we[1]), .M1_sel_i(sel[1]),
    .M1_adr_i(adr[1]), .M1_dat_i(wdat[1]), .M1_dat_o(rdat[1]), .M1_ack_o(ack_o[1]), .M1_err_o(err_o[1]),
    .S_cyc_o(s_cyc), .S_stb_o(s_stb), .S_we_o(s_we), .S_sel_o(s_sel), .S_adr_o(s_adr),
    .S_dat_o(s_wdat), .S_dat_i(s_rdat), .S_ack_i(s_ack), .gnt_o(gnt), .timeout_o(timeout)
  );

  // reference model: owner index (-1 idle), last winner, count of consecutive un-acked strobes
  task automatic tick();
    int o;
    logic act, sn, ex;
    o = own < 0 ? 0 : own;
    act = own >= 0 && cyc[o];
    sn = act && stb[o];
    ex = sn && !s_ack && waited == TO - 1;
    if (rst) begin
      own = -1;
      lst = 1;
      waited = 0;
    end else begin
      waited = (sn && !s_ack && !ex) ? waited + 1 : 0;
      if (own < 0) begin
        own = (cyc[0] && cyc[1]) ? 1 - lst : cyc[0] ? 0 : cyc[1] ? 1 : -1;
        if (own >= 0) lst = own;
      end else if (!act || ex) own = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0; s_ack = 1'b0;
    for (int m = 0; m < 2; m++) begin
      sel[m] = '0; adr[m] = '0; wdat[m] = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    s_rdat = 32'h0BAD_F00D;
    rst = 1'b1;
    tick();
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL rst_gnt: got %b want 00", gnt); end
    checks++; if ({s_cyc, s_stb, s_we, s_sel} !== 7'd0) begin fails++; $display("FAIL rst_sbus: got %b want 0", {s_cyc, s_stb, s_we, s_sel}); end
    checks++; if ({ack_o, err_o, timeout} !== 5'd0) begin fails++; $display("FAIL rst_resp: got %b want 00000", {ack_o, err_o, timeout}); end
    rst = 1'b0;
    s_ack = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    cyc[0] = 1; stb[0] = 1; we[0] = 1; sel[0] = 4'hF; adr[0] = 16'h0010; wdat[0] = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if ({gnt, s_cyc} !== 3'b000) begin fails++; $display("FAIL wr_latency: got %b want 000", {gnt, s_cyc}); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL wr_gnt: got %b want 01", gnt); end
    checks++; if (s_adr !== 16'h0010) begin fails++; $display("FAIL wr_adr: got %h want 0010", s_adr); end
    checks++; if (s_wdat !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_dat: got %h want deadbeef", s_wdat); end
    checks++; if ({s_cyc, s_stb, s_we, s_sel} !== 7'b1111111) begin fails++; $display("FAIL wr_ctl: got %b want 1111111", {s_cyc, s_stb, s_we, s_sel}); end
    tick();
    @(negedge clk);
    checks++; if (ack_o !== 2'b00) begin fails++; $display("FAIL wr_noack: got %b want 00", ack_o); end
    tick();
    s_ack = 1;
    @(negedge clk);
    checks++; if ({ack_o, err_o} !== 4'b0100) begin fails++; $display("FAIL wr_ack: got %b want 0100", {ack_o, err_o}); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if ({s_cyc, s_stb, ack_o} !== 4'b0000) begin fails++; $display("FAIL wr_release: got %b want 0000", {s_cyc, s_stb, ack_o}); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL wr_idle: got %b want 00", gnt); end
    tick();
  endtask

  task automatic test_tie_alternation();
    do_reset();
    cyc = 2'b11; stb = 2'b11; adr[0] = 16'h1000; adr[1] = 16'h2000;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if ({gnt, s_adr} !== {2'b01, 16'h1000}) begin fails++; $display("FAIL tie_first: got %b/%h want 01/1000", gnt, s_adr); end
    tick();
    cyc[0] = 0; stb[0] = 0;
    @(negedge clk);
    checks++; if (s_cyc !== 1'b0) begin fails++; $display("FAIL tie_drop: got %b want 0", s_cyc); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL tie_gap: got %b want 00", gnt); end
    tick();
    @(negedge clk);
    checks++; if ({gnt, s_adr} !== {2'b10, 16'h2000}) begin fails++; $display("FAIL tie_second: got %b/%h want 10/2000", gnt, s_adr); end
    tick();
    cyc = 2'b00; stb = 2'b00;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL tie_idle: got %b want 00", gnt); end
    cyc = 2'b11; stb = 2'b11;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL tie_alternate: got %b want 01", gnt); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_read_m1();
    do_reset();
    cyc[1] = 1; stb[1] = 1; adr[1] = 16'h0044;
    tick();
    s_ack = 1; s_rdat = 32'h12345678;
    @(negedge clk);
    checks++; if (rdat[1] !== 32'h12345678) begin fails++; $display("FAIL rd_dat: got %h want 12345678", rdat[1]); end
    checks++; if (ack_o !== 2'b10) begin fails++; $display("FAIL rd_ack: got %b want 10", ack_o); end
    checks++; if ({s_we, gnt} !== 3'b010) begin fails++; $display("FAIL rd_ctl: got %b want 010", {s_we, gnt}); end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    cyc[0] = 1; stb[0] = 1;
    tick();
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      checks++;
      if ({err_o[0], timeout, s_stb, s_cyc} !== (i == TO ? 4'b1100 : 4'b0011)) begin
        fails++; $display("FAIL to_cycle%0d: got %b want %b", i, {err_o[0], timeout, s_stb, s_cyc}, (i == TO ? 4'b1100 : 4'b0011));
      end
      tick();
    end
    @(negedge clk);
    checks++; if ({gnt, err_o, timeout} !== 5'd0) begin fails++; $display("FAIL to_idle: got %b want 00000", {gnt, err_o, timeout}); end
    tick();
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      checks++; if ({gnt, s_stb, timeout, err_o} !== 6'b011000) begin fails++; $display("FAIL to_rearb%0d: got %b want 011000", i, {gnt, s_stb, timeout, err_o}); end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_ack_at_expiry();
    do_reset();
    cyc[0] = 1; stb[0] = 1;
    tick();
    for (int i = 1; i < TO; i++) tick();
    s_ack = 1;
    @(negedge clk);
    checks++; if ({ack_o, err_o, timeout, s_stb} !== 6'b010001) begin fails++; $display("FAIL ack_exp: got %b want 010001", {ack_o, err_o, timeout, s_stb}); end
    tick();
    s_ack = 0;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL ack_exp_hold: got %b want 01", gnt); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'h3; adr[1] = 16'hBEEF; wdat[1] = 32'hCAFEF00D;
    tick();
    @(negedge clk);
    checks++; if ({gnt, s_stb} !== 3'b101) begin fails++; $display("FAIL rm_pre: got %b want 101", {gnt, s_stb}); end
    rst = 1;
    tick();
    s_ack = 1;
    @(negedge clk);
    checks++; if ({gnt, s_cyc, s_stb, s_we, s_sel} !== 9'd0) begin fails++; $display("FAIL rm_ctl: got %b want 0", {gnt, s_cyc, s_stb, s_we, s_sel}); end
    checks++; if ({s_adr, s_wdat} !== 48'd0) begin fails++; $display("FAIL rm_data: got %h want 0", {s_adr, s_wdat}); end
    checks++; if ({ack_o, err_o} !== 4'd0) begin fails++; $display("FAIL rm_resp: got %b want 0000", {ack_o, err_o}); end
    rst = 0; s_ack = 0; cyc = 2'b11; stb = 2'b11;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL rm_tie: got %b want 01", gnt); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    int o;
    logic act, sn, ex;
    logic [1:0] e_gnt, e_ack, e_err;
    logic [2:0] e_bus;
    logic [3:0] e_sel;
    logic [AW-1:0] e_adr;
    logic [31:0] e_wd;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 11) == 0) cyc[m] = !cyc[m];
        stb[m] = cyc[m] & ($urandom_range(0, 7) != 0);
        we[m] = 1'($urandom);
        sel[m] = 4'($urandom);
        adr[m] = AW'($urandom);
        wdat[m] = $urandom;
      end
      s_ack = (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : 1'b0;
      s_rdat = $urandom;
      @(negedge clk);
      o = own < 0 ? 0 : own;
      act = own >= 0 && cyc[o];
      sn = act && stb[o];
      ex = sn && !s_ack && waited == TO - 1;
      e_gnt = own < 0 ? 2'b00 : own == 0 ? 2'b01 : 2'b10;
      e_bus = {act && !ex, sn && !ex, act && we[o]};
      e_sel = act ? sel[o] : '0;
      e_adr = act ? adr[o] : '0;
      e_wd = act ? wdat[o] : '0;
      e_ack = {own == 1 && s_ack && stb[1], own == 0 && s_ack && stb[0]};
      e_err = {own == 1 && ex, own == 0 && ex};
      checks++; if (gnt !== e_gnt) begin fails++; $display("FAIL rnd_gnt @%0d: got %b want %b", n, gnt, e_gnt); end
      checks++; if ({s_cyc, s_stb, s_we} !== e_bus) begin fails++; $display("FAIL rnd_bus @%0d: got %b want %b", n, {s_cyc, s_stb, s_we}, e_bus); end
      checks++; if ({s_sel, s_adr, s_wdat} !== {e_sel, e_adr, e_wd}) begin fails++; $display("FAIL rnd_mux @%0d: got %h want %h", n, {s_sel, s_adr, s_wdat}, {e_sel, e_adr, e_wd}); end
      checks++; if ({ack_o, err_o, timeout} !== {e_ack, e_err, ex}) begin fails++; $display("FAIL rnd_resp @%0d: got %b want %b", n, {ack_o, err_o, timeout}, {e_ack, e_err, ex}); end
      checks++; if ({rdat[0], rdat[1]} !== {s_rdat, s_rdat}) begin fails++; $display("FAIL rnd_rdat @%0d: got %h want %h", n, {rdat[0], rdat[1]}, {s_rdat, s_rdat}); end
      tick();
    end
    rst = 0;
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    s_rdat = '0;
    test_reset();
    test_single_write();
    test_tie_alternation();
    test_read_m1();
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/wb_arbiter_2m_rr.md
Name: wb_arbiter_2m_rr

Overview:
- Two-master, single-slave Wishbone arbiter with round-robin fairness and a bus-timeout watchdog.
- Shares one 32-bit slave port between the host CPU master and a second master (e.g. a DMA or settings engine). The slave port feeds the 32-to-16 Wishbone bridge in front of the 16-bit peripheral bus.
- Grants are held for a whole Wishbone cycle (CYC high). A stalled slave is released with an error termination.

Parameters:
- AWIDTH, 16, address width of all ports.
- TIMEOUT, 255, number of consecutive un-acked strobe cycles before a forced error termination (range 2..2^TWIDTH-1).
- TWIDTH, 8, width of the watchdog counter.

Ports:
- wb_clk  in  1  system clock, all logic on rising edge
- wb_rst  in  1  synchronous, active-high reset
- M0_cyc_i, M0_stb_i, M0_we_i  in  1 each  master 0 cycle/strobe/write
- M0_sel_i  in  4  master 0 byte selects
- M0_adr_i  in  AWIDTH  master 0 address
- M0_dat_i  in  32  master 0 write data
- M0_dat_o  out  32  master 0 read data
- M0_ack_o  out  1  master 0 acknowledge
- M0_err_o  out  1  master 0 error (timeout)
- M1_* identical set for master 1
- S_cyc_o, S_stb_o, S_we_o  out  1 each  slave cycle/strobe/write
- S_sel_o  out  4  slave byte selects
- S_adr_o  out  AWIDTH  slave address
- S_dat_o  out  32  slave write data
- S_dat_i  in  32  slave read data
- S_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot current grant ({M1,M0}), 00 when idle
- timeout_o  out  1  one-cycle pulse on every watchdog expiry

Behaviour:
- FSM states: IDLE, GNT0, GNT1 (registered). Register last_gnt holds 0 or 1.
- Reset: state=IDLE, last_gnt=1 (so M0 wins the first tie), watchdog=0. gnt_o=00, timeout_o=0, all S_* outputs 0, all M*_ack_o/err_o 0.
- IDLE transitions:
  - only M0_cyc_i -> GNT0.
  - only M1_cyc_i -> GNT1.
  - both -> grant the master != last_gnt.
  - none -> stay in IDLE.
- Arbitration latency: a request first seen in IDLE drives S_cyc_o on the next cycle.
- GNTn -> IDLE when Mn_cyc_i is low; S_* go low in that same cycle (combinational gating). last_gnt<=n on entry to GNTn.
- Every grant passes through IDLE for at least one cycle; there is no back-to-back handover. The bridge's phase register therefore sees S_stb_o low between masters.
- Slave mux (combinational from state):
  - In GNTn, S_cyc_o/stb/we/sel/adr/dat = Mn's signals.
  - In IDLE, all S_* = 0.
- Return path:
  - Mn_dat_o = S_dat_i, unconditionally.
  - Mn_ack_o = S_ack_i & Mn_stb_i & (state==GNTn).
  - The non-granted master never sees ack or err.
- Watchdog:
  - Increments each cycle that S_stb_o=1 and S_ack_i=0.
  - Clears when S_ack_i=1, when S_stb_o=0, or on expiry.
  - Expiry is the cycle where count==TIMEOUT-1 with no ack. In that cycle:
    - Mn_err_o=1 and timeout_o=1.
    - S_cyc_o and S_stb_o are forced low.
    - The FSM goes to IDLE regardless of Mn_cyc_i. If Mn keeps CYC high, it is re-arbitrated as a fresh request.
- Ack and expiry in the same cycle: ack wins, no err, watchdog clears.
- The ack/err pair is never asserted together.
- Reset mid-transfer: all outputs drop on the cycle after wb_rst is sampled high. The in-flight access is abandoned with no ack or err.
- A master dropping CYC without receiving an ack is legal: the grant is released and the watchdog clears.

Test Plan:
- M0 single write adr=0x0010, dat=0xDEADBEEF, slave acks 2 cycles after S_stb_o -> S_adr_o=0x0010, S_dat_o=0xDEADBEEF; M0_ack_o for 1 cycle; M1_ack_o stays 0; gnt_o=01 then 00.
- M0 and M1 both raise CYC in the same cycle right after reset -> M0 granted first. After M0 drops CYC: 1 idle cycle, then M1 granted (gnt_o 01, 00, 10). Repeat the tie -> M0 granted again (alternation).
- M1 read with S_dat_i=0x12345678 at ack -> M1_dat_o=0x12345678 with M1_ack_o=1; M0 sees no ack.
- Slave never acks, TIMEOUT=8 -> M0_err_o and timeout_o high on the 8th strobe cycle. S_stb_o low that cycle, state returns to IDLE, counter reads 0.
- S_ack_i arrives exactly on the 8th cycle -> M0_ack_o=1, M0_err_o=0, timeout_o=0.
- wb_rst asserted while M1 is granted with S_stb_o high -> next cycle all S_* outputs and gnt_o are 0. After release, a tie grants M0 first.
